// File: rtl/frame_scheduler.sv
// Per-frame game-task sequencer slaved to the VGA raster position.
// Once per divided blanking interval it walks paddle, ball and bricks through a req/done handshake.
module frame_scheduler #(
    parameter int V_VISIBLE = 600,
    parameter int FRAME_DIV = 1,
    parameter int TIMEOUT   = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [10:0] Hpos,
    input  logic [10:0] Vpos,
    input  logic        pause,
    input  logic [2:0]  done,
    output logic        vga_enable,
    output logic [2:0]  req,
    output logic        frame_tick,
    output logic        busy,
    output logic        timeout,
    output logic        overrun,
    output logic [15:0] frame_count
);
    localparam logic [10:0] V_BLANK  = 11'(V_VISIBLE);
    localparam logic [7:0]  DIV_LAST = 8'(FRAME_DIV);
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_TASK0 = 3'd1,
        S_TASK1 = 3'd2,
        S_TASK2 = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t      state_q, state_d;
    state_t      next_task_s;
    logic [2:0]  cur_bit_s;
    logic        task_ack_s;
    logic [7:0]  div_inc_s;

    logic        blank_hit_q, blank_hit_d, blank_prev_q, blank_prev_d, blank_ev_q, blank_ev_d;
    logic        frame_hit_q, frame_hit_d, frame_prev_q, frame_prev_d, frame_ev_q, frame_ev_d;
    logic [7:0]  div_cnt_q, div_cnt_d;
    logic [15:0] tmo_cnt_q, tmo_cnt_d;
    logic [2:0]  req_q, req_d;
    logic        frame_tick_q, frame_tick_d;
    logic        busy_q, busy_d;
    logic        timeout_q, timeout_d;
    logic        overrun_q, overrun_d;
    logic [15:0] frame_count_q, frame_count_d;
    logic        vga_enable_q, vga_enable_d;

    // Which request bit is live and where the sequence goes once it is acknowledged or expires.
    always_comb begin
        case (state_q)
            S_TASK0: begin cur_bit_s = 3'b001; next_task_s = S_TASK1; end
            S_TASK1: begin cur_bit_s = 3'b010; next_task_s = S_TASK2; end
            S_TASK2: begin cur_bit_s = 3'b100; next_task_s = S_DONE;  end
            default: begin cur_bit_s = 3'b000; next_task_s = S_IDLE;  end
        endcase
        task_ack_s = |(done & cur_bit_s);
        div_inc_s  = div_cnt_q + 8'd1;
    end

    // Edge-detected raster events and sequencer next-state logic.
    always_comb begin
        blank_hit_d   = (Vpos == V_BLANK) && (Hpos == 11'd0);
        frame_hit_d   = (Vpos == 11'd0) && (Hpos == 11'd0);
        blank_prev_d  = blank_hit_q;
        frame_prev_d  = frame_hit_q;
        blank_ev_d    = blank_hit_q && !blank_prev_q;
        frame_ev_d    = frame_hit_q && !frame_prev_q;
        vga_enable_d  = 1'b1;
        state_d       = state_q;
        div_cnt_d     = div_cnt_q;
        tmo_cnt_d     = tmo_cnt_q;
        timeout_d     = timeout_q;

        // Blank events are always counted, even when dropped by a running sequence.
        if (blank_ev_q) begin
            frame_count_d = frame_count_q + 16'd1;
        end else begin
            frame_count_d = frame_count_q;
        end

        case (state_q)
            S_IDLE: begin
                if (blank_ev_q && !pause) begin
                    if (div_inc_s == DIV_LAST) begin
                        div_cnt_d = 8'd0;
                        tmo_cnt_d = 16'd0;
                        state_d   = S_TASK0;
                    end else begin
                        div_cnt_d = div_inc_s;
                    end
                end else begin
                    div_cnt_d = div_cnt_q;
                end
            end
            S_TASK0, S_TASK1, S_TASK2: begin
                if (task_ack_s) begin
                    state_d   = next_task_s;
                    tmo_cnt_d = 16'd0;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = next_task_s;
                    tmo_cnt_d = 16'd0;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 16'd1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if ((state_q != S_IDLE) && (blank_ev_q || frame_ev_q)) begin
            overrun_d = 1'b1;
        end else begin
            overrun_d = overrun_q;
        end

        // Outputs are decoded from the next state so they register alongside it.
        case (state_d)
            S_TASK0: req_d = 3'b001;
            S_TASK1: req_d = 3'b010;
            S_TASK2: req_d = 3'b100;
            default: req_d = 3'b000;
        endcase
        busy_d       = (state_d != S_IDLE);
        frame_tick_d = (state_d == S_DONE);
    end

    // All sequencer state, cleared asynchronously so requests drop the instant reset rises.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            blank_hit_q   <= 1'b0;
            blank_prev_q  <= 1'b0;
            blank_ev_q    <= 1'b0;
            frame_hit_q   <= 1'b0;
            frame_prev_q  <= 1'b0;
            frame_ev_q    <= 1'b0;
            div_cnt_q     <= 8'd0;
            tmo_cnt_q     <= 16'd0;
            req_q         <= 3'b000;
            frame_tick_q  <= 1'b0;
            busy_q        <= 1'b0;
            timeout_q     <= 1'b0;
            overrun_q     <= 1'b0;
            frame_count_q <= 16'd0;
            vga_enable_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            blank_hit_q   <= blank_hit_d;
            blank_prev_q  <= blank_prev_d;
            blank_ev_q    <= blank_ev_d;
            frame_hit_q   <= frame_hit_d;
            frame_prev_q  <= frame_prev_d;
            frame_ev_q    <= frame_ev_d;
            div_cnt_q     <= div_cnt_d;
            tmo_cnt_q     <= tmo_cnt_d;
            req_q         <= req_d;
            frame_tick_q  <= frame_tick_d;
            busy_q        <= busy_d;
            timeout_q     <= timeout_d;
            overrun_q     <= overrun_d;
            frame_count_q <= frame_count_d;
            vga_enable_q  <= vga_enable_d;
        end
    end

    assign vga_enable  = vga_enable_q;
    assign req         = req_q;
    assign frame_tick  = frame_tick_q;
    assign busy        = busy_q;
    assign timeout     = timeout_q;
    assign overrun     = overrun_q;
    assign frame_count = frame_count_q;

endmodule

// File: tb/tb_frame_scheduler.sv
// Bench for frame_scheduler: directed scenarios plus randomized raster/handshake traffic,
// all checked every cycle against a task-level reference model.
module tb_frame_scheduler;
    localparam int FDIV  = 2;
    localparam int TMO   = 16;
    localparam int NEVER = 1000;

    logic        clk = 1'b0;
    logic        reset;
    logic [10:0] Hpos, Vpos;
    logic        pause;
    logic [2:0]  done;
    logic        vga_enable, frame_tick, busy, timeout, overrun;
    logic [2:0]  req;
    logic [15:0] frame_count;

    always #10 clk = ~clk;

    frame_scheduler #(.V_VISIBLE(600), .FRAME_DIV(FDIV), .TIMEOUT(TMO)) u_dut (
        .clk(clk), .reset(reset), .Hpos(Hpos), .Vpos(Vpos), .pause(pause), .done(done),
        .vga_enable(vga_enable), .req(req), .frame_tick(frame_tick), .busy(busy),
        .timeout(timeout), .overrun(overrun), .frame_count(frame_count)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: phase -1 idle, 0..2 task k, 3 done; age = cycles the current req has been high.
    int          m_phase, m_age, m_div;
    logic [15:0] m_fc;
    logic        m_tmo, m_ovr, m_en;
    logic [3:1]  bh, fh;
    int          dly [3];
    logic        noise_en = 1'b0;
    int          tick_seen;
    int          req_cyc [3];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = -1; m_age = 0; m_div = 0; m_fc = 16'd0;
        m_tmo = 1'b0; m_ovr = 1'b0; m_en = 1'b0; bh = 3'b000; fh = 3'b000;
    endtask

    task automatic advance();
        m_phase = m_phase + 1;
        m_age   = 1;
    endtask

    task automatic model_step();
        logic bev, fev;
        if (reset) begin
            model_reset();
            return;
        end
        m_en = 1'b1;
        bev  = bh[2] && !bh[3];
        fev  = fh[2] && !fh[3];
        bh   = {bh[2:1], (Vpos == 11'd600) && (Hpos == 11'd0)};
        fh   = {fh[2:1], (Vpos == 11'd0) && (Hpos == 11'd0)};
        if (bev) m_fc = m_fc + 16'd1;
        if (m_phase != -1 && (bev || fev)) m_ovr = 1'b1;
        if (m_phase == -1) begin
            if (bev && !pause) begin
                m_div++;
                if (m_div == FDIV) begin
                    m_div   = 0;
                    m_phase = 0;
                    m_age   = 1;
                end
            end
        end else if (m_phase == 3) begin
            m_phase = -1;
        end else if (done[m_phase]) begin
            advance();
        end else if (m_age == TMO) begin
            m_tmo = 1'b1;
            advance();
        end else begin
            m_age++;
        end
    endtask

    task automatic compare();
        logic [2:0] er;
        er = 3'b000;
        if (m_phase >= 0 && m_phase <= 2) er[m_phase] = 1'b1;
        chk("req", 32'(req), 32'(er));
        chk("busy", 32'(busy), 32'(m_phase != -1));
        chk("frame_tick", 32'(frame_tick), 32'(m_phase == 3));
        chk("timeout", 32'(timeout), 32'(m_tmo));
        chk("overrun", 32'(overrun), 32'(m_ovr));
        chk("frame_count", 32'(frame_count), 32'(m_fc));
        chk("vga_enable", 32'(vga_enable), 32'(m_en));
        tick_seen += int'(frame_tick);
        for (int k = 0; k < 3; k++) req_cyc[k] += int'(req[k]);
    endtask

    task automatic respond();
        logic [2:0] d;
        d = noise_en ? 3'($urandom_range(0, 7)) : 3'b000;
        if (m_phase >= 0 && m_phase <= 2) d[m_phase] = (m_age > dly[m_phase]);
        done = d;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare();
        respond();
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic set_pos(input int v, input int h);
        Vpos = 11'(v);
        Hpos = 11'(h);
    endtask

    task automatic clear_obs();
        tick_seen = 0;
        for (int k = 0; k < 3; k++) req_cyc[k] = 0;
    endtask

    task automatic set_dly(input int d0, input int d1, input int d2);
        dly[0] = d0; dly[1] = d1; dly[2] = d2;
    endtask

    // One blank hit held for 'hold' cycles, then enough cycles for the event to be acted on.
    task automatic blank(input int hold, input logic p);
        pause = p;
        set_pos(600, 0);
        run(hold);
        set_pos(601, 3);
        run(3);
        pause = 1'b0;
    endtask

    task automatic run_until_idle(input int budget);
        int i;
        i = 0;
        while (m_phase != -1 && i < budget) begin
            cycle();
            i++;
        end
        n_vec++;
        if (m_phase != -1) begin
            n_err++;
            $display("FAIL idle_wait: sequence still active after %0d cycles", budget);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; pause = 1'b0; done = 3'b000;
        set_pos(601, 3);
        set_dly(5, 5, 5);
        model_reset();
        clear_obs();
        #1;
        chk("rst_req", 32'(req), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_en", 32'(vga_enable), 32'd0);
        chk("rst_fc", 32'(frame_count), 32'd0);
        chk("rst_flags", 32'({frame_tick, timeout, overrun}), 32'd0);
        run(5);
        reset = 1'b0;
        cycle();
        chk("en_after_reset", 32'(vga_enable), 32'd1);

        // Normal frame: divider of two needs a second blank; pin hit->req latency on it.
        blank(1, 1'b0);
        clear_obs();
        set_pos(600, 0);
        cycle();
        set_pos(601, 3);
        cycle();
        chk("latency_n1", 32'(req), 32'd0);
        cycle();
        chk("latency_n2", 32'(req), 32'b001);
        run_until_idle(60);
        chk("normal_req0_cycles", 32'(req_cyc[0]), 32'd6);
        chk("normal_req1_cycles", 32'(req_cyc[1]), 32'd6);
        chk("normal_req2_cycles", 32'(req_cyc[2]), 32'd6);
        chk("normal_ticks", 32'(tick_seen), 32'd1);
        chk("normal_fc", 32'(frame_count), 32'd2);

        // Divider and pause: only the third of four blanks runs a sequence.
        clear_obs();
        blank(1, 1'b0); run(2);
        blank(1, 1'b1); run(2);
        blank(1, 1'b0); run_until_idle(60);
        blank(1, 1'b0); run(2);
        chk("pause_ticks", 32'(tick_seen), 32'd1);
        chk("pause_fc", 32'(frame_count), 32'd6);

        // Timeout on the ball task.
        set_dly(5, NEVER, 5);
        clear_obs();
        blank(1, 1'b0);
        run_until_idle(80);
        chk("tmo_req1_cycles", 32'(req_cyc[1]), 32'(TMO));
        chk("tmo_req2_cycles", 32'(req_cyc[2]), 32'd6);
        chk("tmo_flag", 32'(timeout), 32'd1);
        chk("tmo_ticks", 32'(tick_seen), 32'd1);

        // Overrun: frame start and a second blank both land inside TASK0.
        set_dly(NEVER, 5, 5);
        blank(1, 1'b0); run(2);
        blank(1, 1'b0);
        clear_obs();
        set_pos(0, 0);
        cycle();
        set_pos(5, 5);
        run(3);
        chk("ovr_flag", 32'(overrun), 32'd1);
        chk("ovr_req_held", 32'(req), 32'b001);
        blank(1, 1'b0);
        chk("ovr_fc", 32'(frame_count), 32'd10);
        chk("ovr_no_restart", 32'(req), 32'b001);
        run_until_idle(80);
        chk("ovr_ticks", 32'(tick_seen), 32'd1);

        // Frozen raster position produces a single event.
        set_dly(1, 1, 1);
        blank(1, 1'b0); run(2);
        clear_obs();
        set_pos(600, 0);
        run(50);
        set_pos(601, 3);
        run(5);
        chk("frozen_ticks", 32'(tick_seen), 32'd1);
        chk("frozen_fc", 32'(frame_count), 32'd12);

        // Reset asserted mid-TASK1 clears req without any clock edge.
        set_dly(5, 5, 5);
        blank(1, 1'b0); run(2);
        blank(1, 1'b0);
        while (m_phase != 1) cycle();
        clear_obs();
        #5;
        reset = 1'b1;
        model_reset();
        #1;
        chk("midreset_req", 32'(req), 32'd0);
        chk("midreset_busy", 32'(busy), 32'd0);
        run(3);
        reset = 1'b0;
        run(20);
        chk("midreset_ticks", 32'(tick_seen), 32'd0);
        chk("midreset_fc", 32'(frame_count), 32'd0);

        // Randomized raster, pause, handshake and reset traffic.
        noise_en = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                case ($urandom_range(0, 5))
                    0, 1:    set_pos(600, 0);
                    2:       set_pos(0, 0);
                    3:       set_pos(600, 1);
                    4:       set_pos(0, 1);
                    default: set_pos(int'($urandom_range(0, 800)), int'($urandom_range(0, 1000)));
                endcase
            end
            pause = ($urandom_range(0, 3) == 0);
            if (m_phase == -1) begin
                for (int k = 0; k < 3; k++)
                    dly[k] = ($urandom_range(0, 5) == 0) ? 20 : int'($urandom_range(0, 6));
            end
            reset = ($urandom_range(0, 499) == 0);
            if (reset) model_reset();
            cycle();
        end
        reset = 1'b0;
        run(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
